fast_to_slow_pulse_tx: RTL

FAST_TO_SLOW_PULSE_TX -- requirements
Module: fast_to_slow_pulse_tx

---
 rtl/fast_to_slow_pulse_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/fast_to_slow_pulse_tx.sv
// Carries single-cycle fast_clk events to a slow domain with a 4-phase req/ack handshake.
// Latency 2*SYNC_STAGES+3 cycles minimum; pulses that arrive while busy are dropped and counted.
module fast_to_slow_pulse_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic             fast_clk,
  input  logic             rst_n,
  input  logic             pulse_fast_in,
  input  logic             ack_slow_in,
  output logic             req_level_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             drop_out,
  output logic             timeout_out,
  output logic [CNT_W-1:0] drop_count
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW:0] TO_VAL = TIMEOUT[TW:0];

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_HI      = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [TW:0]            cnt_inc;
  logic                   tmo_hit;

  logic req_q, req_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic drop_q, drop_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Only the last synchronizer stage may be observed by any logic.
  assign ack_s = sync_q[SYNC_STAGES-1];

  assign cnt_inc = {1'b0, cnt_q} + {{TW{1'b0}}, 1'b1};
  assign tmo_hit = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_inc >= TO_VAL);

  // State register together with the synchronizer, phase counter and output flops.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ack_slow_in};
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Next state: a real ack edge always wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (pulse_fast_in) state_d = REQ_HI;
      REQ_HI:      if (ack_s) state_d = WAIT_ACK_LO;
                   else if (tmo_hit) state_d = IDLE;
      WAIT_ACK_LO: if (!ack_s) state_d = IDLE;
                   else if (tmo_hit) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = (state_d == REQ_HI);
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == WAIT_ACK_LO) && !ack_s;
    timeout_d  = (state_q != IDLE) && (state_d == IDLE) && !done_d;
    drop_d     = pulse_fast_in && (state_q != IDLE);
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_inc[TW-1:0];
    end
  end

  assign req_level_out = req_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign drop_out      = drop_q;
  assign timeout_out   = timeout_q;
  assign drop_count    = drop_cnt_q;

endmodule
